montgomery_precompute: RTL and testbench
========================================

Name: montgomery_precompute

Overview:
Per-modulus constant generator that sits directly upstream of montgomery_pipelined.
- Given an odd modulus m, it computes K = bit length of m (so R = 2^K, equal to $clog2(m) for odd m ≥ 3).
- It computes minv = -m^-1 mod 2^K, which drives the reducer's minv_i.
- It computes r2 = R^2 mod m, the constant used to convert operands into Montgomery form.
- Bit-serial, multiplier-free, one modulus in flight at a time.

Parameters:
WIDTH, 64, operand/modulus width in bits (≥ 4)
KW, $clog2(WIDTH)+1, width of the bit-length output

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset, asynchronous, active-low
start_i  input  1  request; accepted only when ready_o=1
m_i  input  WIDTH  modulus, sampled on the accepting edge
ready_o  output  1  high in IDLE only
valid_o  output  1  one-cycle pulse; minv_o, r2_o, k_o valid
err_o  output  1  one-cycle pulse; modulus rejected
k_o  output  KW  bit length K of m
minv_o  output  WIDTH  -m^-1 mod 2^K, upper bits zero
r2_o  output  WIDTH  2^(2K) mod m

Behaviour:
- Reset values (asynchronous, all outputs registered):
  - state=IDLE, ready_o=1, valid_o=0, err_o=0.
  - k_o, minv_o and r2_o are 0.
- Data outputs hold their last values until the next valid_o; they do not change on err_o.
- States: IDLE, SIZE, INV, R2, DONE, ERR.
- IDLE:
  - start_i=1: latch m, go to SIZE.
  - start_i=0: stay in IDLE.
  - start_i is ignored in every other state; it is not queued.
- SIZE (1 cycle):
  - K = index of MSB of m, plus 1 (priority encoder).
  - If m[0]=0 or m<3, go to ERR.
  - Otherwise initialise x=1, t=m, i=1, go to INV.
- INV (K-1 cycles, Hensel lifting):
  - If t[i]=1, set x[i]=1 and t = t + (m << i), truncated to WIDTH.
  - Then i++.
  - After step i = K-1, compute minv = (2^K - x) masked to K bits.
  - Initialise r = 2^K - m (0 < r < m), j=0, go to R2.
- R2 (K cycles):
  - r = 2r; if r ≥ m, r = r - m.
  - The intermediate is WIDTH+1 bits so K=WIDTH does not overflow.
  - After K steps, go to DONE.
- DONE (1 cycle):
  - valid_o=1 with k_o, minv_o, r2_o updated.
  - Next state is IDLE.
- ERR (1 cycle):
  - err_o=1, then IDLE.
- Latency:
  - With start accepted at edge 0, valid_o is observed high at edge 2K+1.
  - ready_o returns at edge 2K+2.
  - Error path: err_o is observed at edge 2, ready_o returns at edge 3.
- Simultaneous events: valid_o and err_o are never high together. A start_i in the same cycle as DONE is ignored.
- Reset mid-operation:
  - Abort immediately and return to IDLE with reset values.
  - No valid_o or err_o for the aborted request.
- Invariants:
  - In INV, before step i, t ≡ m·x and t[i-1:0] = 1.
  - Final m·x ≡ 1 mod 2^K.
  - The bench checks m·minv_o + 1 ≡ 0 mod 2^k_o.

Decomposition:
- multiplier_pkg gets:
  - the enum typedef precomp_state_t {IDLE, SIZE, INV, R2, DONE, ERR};
  - a constant PRECOMP_MIN_MOD = 3.
- One natural sub-module, mont_modinv_serial, holds the INV datapath: x/t registers, step counter, done flag.
- The R2 doubling loop and the FSM stay in the top module.

Test Plan:
- m=13 -> k_o=4, minv_o=11, r2_o=9; valid_o observed at edge 9 after the start edge, single cycle.
- m=3 -> k_o=2, minv_o=1, r2_o=1.
- m=2^64-1 -> k_o=64, minv_o=1, r2_o=1 (full-width overflow check).
- m=2^60+1 -> k_o=61, minv_o=2^60-1, r2_o=4.
- m=12, then m=1 -> err_o pulse at edge 2 each, no valid_o, data outputs unchanged.
- m=13 started, rst_ni low at edge 5 and released, start_i held high throughout INV/R2:
  - no valid_o for the aborted run;
  - outputs read 0 after reset;
  - the next request (m=13) gives valid_o at edge 9 with correct values;
  - a start_i pulse during busy does not spawn a second result.

Source files
------------

// File: rtl/multiplier_pkg.sv
// Shared definitions for the Montgomery multiplier family.
//   precomp_state_t : state encoding of the montgomery_precompute FSM
//   PRECOMP_MIN_MOD : smallest modulus montgomery_precompute accepts
package multiplier_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SIZE = 3'd1,
    INV  = 3'd2,
    R2   = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } precomp_state_t;

  localparam int unsigned PRECOMP_MIN_MOD = 3;

endpackage

// File: rtl/mont_modinv_serial.sv
// Bit-serial Hensel lifting of m^-1 mod 2^K, one bit per step.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   init_i        : load x=1, t=m, i=1 (m odd, so bit 0 is already solved)
//   step_i        : perform one lifting step at bit index i
//   m_i           : modulus (held stable by the caller)
//   k_i           : bit length K of m
//   x_o           : running inverse x, with m*x = 1 mod 2^i
//   done_o        : the step in progress is the last one (i = K-1)
module mont_modinv_serial
  import multiplier_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int KW    = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             init_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic [KW-1:0]    k_i,
  output logic [WIDTH-1:0] x_o,
  output logic             done_o
);

  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [KW-1:0]    i_q, i_d;
  logic [IW-1:0]    idx;

  // i never reaches WIDTH during a step, so the narrow index is exact.
  assign idx    = i_q[IW-1:0];
  assign done_o = (i_q == k_i - KW'(1));
  assign x_o    = x_q;

  // t tracks m*x; a set bit at position i means x needs bit i to clear it.
  always_comb begin
    x_d = x_q;
    t_d = t_q;
    i_d = i_q;
    if (init_i) begin
      x_d = WIDTH'(1);
      t_d = m_i;
      i_d = KW'(1);
    end else if (step_i) begin
      if (t_q[idx]) begin
        x_d[idx] = 1'b1;
        t_d      = t_q + (m_i << i_q);
      end
      i_d = i_q + KW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      i_q <= '0;
    end else begin
      i_q <= i_d;
    end
  end

  always_ff @(posedge clk_i) begin
    x_q <= x_d;
    t_q <= t_d;
  end

endmodule

// File: rtl/montgomery_precompute.sv
// Per-modulus constant generator for montgomery_pipelined.
// For an odd modulus m >= 3 it produces K (bit length, R = 2^K),
// minv = -m^-1 mod 2^K and r2 = R^2 mod m, bit-serially, no multipliers.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i, m_i  : request and modulus, taken only while ready_o=1
//   ready_o       : idle and able to accept a request
//   valid_o       : one-cycle pulse, k_o/minv_o/r2_o freshly updated
//   err_o         : one-cycle pulse, modulus even or below 3
//   k_o, minv_o, r2_o : results, held until the next valid_o
module montgomery_precompute
  import multiplier_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int KW    = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] m_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic             err_o,
  output logic [KW-1:0]    k_o,
  output logic [WIDTH-1:0] minv_o,
  output logic [WIDTH-1:0] r2_o
);

  precomp_state_t state_q, state_d;

  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [KW-1:0]    kcur_q, kcur_d;
  logic [KW-1:0]    j_q, j_d;

  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] minv_q, minv_d;
  logic [WIDTH-1:0] r2_q, r2_d;

  logic             inv_init, inv_step, inv_done;
  logic [WIDTH-1:0] inv_x;

  logic [KW-1:0]    bitlen;
  logic [WIDTH-1:0] kmask;
  logic [WIDTH-1:0] r_init;
  logic             dbl_ge;
  logic [WIDTH-1:0] r_dbl;

  // Priority encoder: the highest set bit wins.
  always_comb begin
    bitlen = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (m_q[b]) bitlen = KW'(b + 1);
    end
  end

  // Shifting by K = WIDTH yields zero, so the mask becomes all ones.
  assign kmask = ~({WIDTH{1'b1}} << kcur_q);

  // 2^K - m evaluated mod 2^WIDTH; exact because 0 < 2^K - m < m.
  assign r_init = (WIDTH'(1) << kcur_q) - m_q;

  // Doubling compares on WIDTH+1 bits so the carry out of r is kept;
  // the difference itself is below m and fits in WIDTH bits.
  assign dbl_ge = ({r_q, 1'b0} >= {1'b0, m_q});
  assign r_dbl  = dbl_ge ? ({r_q[WIDTH-2:0], 1'b0} - m_q) : {r_q[WIDTH-2:0], 1'b0};

  mont_modinv_serial #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_modinv (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .init_i (inv_init),
    .step_i (inv_step),
    .m_i    (m_q),
    .k_i    (kcur_q),
    .x_o    (inv_x),
    .done_o (inv_done)
  );

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    r_d      = r_q;
    kcur_d   = kcur_q;
    j_d      = j_q;
    k_d      = k_q;
    minv_d   = minv_q;
    r2_d     = r2_q;
    inv_init = 1'b0;
    inv_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          m_d     = m_i;
          state_d = SIZE;
        end
      end
      SIZE: begin
        kcur_d = bitlen;
        if (!m_q[0] || (m_q < WIDTH'(PRECOMP_MIN_MOD))) begin
          state_d = ERR;
        end else begin
          inv_init = 1'b1;
          state_d  = INV;
        end
      end
      INV: begin
        inv_step = 1'b1;
        if (inv_done) begin
          r_d     = r_init;
          j_d     = '0;
          state_d = R2;
        end
      end
      R2: begin
        r_d = r_dbl;
        j_d = j_q + KW'(1);
        if (j_q == kcur_q - KW'(1)) begin
          k_d     = kcur_q;
          minv_d  = (WIDTH'(0) - inv_x) & kmask;
          r2_d    = r_dbl;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up
  // with the cycle the FSM spends in that state.
  assign ready_d = (state_d == IDLE);
  assign valid_d = (state_d == DONE);
  assign err_d   = (state_d == ERR);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      j_q     <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      k_q     <= '0;
      minv_q  <= '0;
      r2_q    <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      k_q     <= k_d;
      minv_q  <= minv_d;
      r2_q    <= r2_d;
    end
  end

  always_ff @(posedge clk_i) begin
    m_q    <= m_d;
    r_q    <= r_d;
    kcur_q <= kcur_d;
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign k_o     = k_q;
  assign minv_o  = minv_q;
  assign r2_o    = r2_q;

endmodule

// File: tb/tb_montgomery_precompute.sv
// Directed bench for montgomery_precompute (WIDTH=64).
// "Observed at edge N" = value sampled on the falling edge just before
// rising edge N, counting the accepting edge as 0.
module tb_montgomery_precompute;

  localparam int WIDTH = 64;
  localparam int KW    = $clog2(WIDTH) + 1;

  logic             clk_i;
  logic             rst_ni;
  logic             start_i;
  logic [WIDTH-1:0] m_i;
  logic             ready_o;
  logic             valid_o;
  logic             err_o;
  logic [KW-1:0]    k_o;
  logic [WIDTH-1:0] minv_o;
  logic [WIDTH-1:0] r2_o;

  int n_total;
  int n_pass;

  montgomery_precompute #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .m_i     (m_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .err_o   (err_o),
    .k_o     (k_o),
    .minv_o  (minv_o),
    .r2_o    (r2_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One request; exp_ok=1 expects a result, 0 expects an error pulse
  // with the data outputs holding exp_k/exp_minv/exp_r2 from before.
  task automatic run_req(input string tag, input logic [63:0] m, input bit exp_ok,
                         input int exp_k, input logic [63:0] exp_minv,
                         input logic [63:0] exp_r2);
    int v_cnt, e_cnt, both, v_edge, e_edge, r_edge;
    logic [63:0] prod, kmask;
    v_cnt = 0; e_cnt = 0; both = 0; v_edge = -1; e_edge = -1; r_edge = -1;
    @(negedge clk_i);
    check_eq({tag, "_ready_idle"}, 64'(ready_o), 64'd1);
    start_i = 1'b1;
    m_i     = m;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    m_i     = ~m;
    for (int c = 1; c <= 140; c++) begin
      @(negedge clk_i);
      if (valid_o) begin v_cnt++; if (v_edge < 0) v_edge = c; end
      if (err_o)   begin e_cnt++; if (e_edge < 0) e_edge = c; end
      if (valid_o && err_o) both++;
      if (ready_o && r_edge < 0) r_edge = c;
    end
    check_eq({tag, "_valid_cnt"}, 64'(v_cnt), exp_ok ? 64'd1 : 64'd0);
    check_eq({tag, "_err_cnt"},   64'(e_cnt), exp_ok ? 64'd0 : 64'd1);
    check_eq({tag, "_both"},      64'(both),  64'd0);
    if (exp_ok) begin
      check_eq({tag, "_valid_edge"}, 64'(v_edge), 64'(2 * exp_k + 1));
      check_eq({tag, "_ready_edge"}, 64'(r_edge), 64'(2 * exp_k + 2));
    end else begin
      check_eq({tag, "_err_edge"},   64'(e_edge), 64'd2);
      check_eq({tag, "_ready_edge"}, 64'(r_edge), 64'd3);
    end
    check_eq({tag, "_k"},    64'(k_o), 64'(exp_k));
    check_eq({tag, "_minv"}, minv_o,   exp_minv);
    check_eq({tag, "_r2"},   r2_o,     exp_r2);
    if (exp_ok) begin
      prod  = m * minv_o;
      kmask = (k_o >= 7'd64) ? '1 : ((64'd1 << k_o) - 64'd1);
      check_eq({tag, "_inv_identity"}, (prod + 64'd1) & kmask, 64'd0);
    end
  endtask

  initial begin
    int v_cnt, e_cnt, v_edge, r_edge, busy;
    n_total = 0;
    n_pass  = 0;
    rst_ni  = 1'b0;
    start_i = 1'b0;
    m_i     = '0;
    repeat (3) @(negedge clk_i);
    check_eq("rst_ready", 64'(ready_o), 64'd1);
    check_eq("rst_valid", 64'(valid_o), 64'd0);
    check_eq("rst_err",   64'(err_o),   64'd0);
    check_eq("rst_k",     64'(k_o),     64'd0);
    check_eq("rst_minv",  minv_o,       64'd0);
    check_eq("rst_r2",    r2_o,         64'd0);
    rst_ni = 1'b1;

    run_req("m13",   64'd13,                   1'b1,  4, 64'd11,                   64'd9);
    run_req("m3",    64'd3,                    1'b1,  2, 64'd1,                    64'd1);
    run_req("mfull", 64'hFFFF_FFFF_FFFF_FFFF,  1'b1, 64, 64'd1,                    64'd1);
    run_req("m2p60", 64'h1000_0000_0000_0001,  1'b1, 61, 64'h0FFF_FFFF_FFFF_FFFF,  64'd4);
    run_req("m5",    64'd5,                    1'b1,  3, 64'd3,                    64'd4);
    run_req("m11",   64'd11,                   1'b1,  4, 64'd13,                   64'd3);
    // Rejected moduli must leave the m=11 results untouched.
    run_req("m12",   64'd12,                   1'b0,  4, 64'd13,                   64'd3);
    run_req("m1",    64'd1,                    1'b0,  4, 64'd13,                   64'd3);

    // Abort m=13 mid-flight with start_i held high throughout.
    v_cnt = 0; e_cnt = 0;
    @(negedge clk_i);
    start_i = 1'b1;
    m_i     = 64'd13;
    @(posedge clk_i);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_i);
      if (valid_o) v_cnt++;
      if (err_o)   e_cnt++;
    end
    rst_ni = 1'b0;
    #1;
    check_eq("abort_ready", 64'(ready_o), 64'd1);
    check_eq("abort_valid", 64'(valid_o), 64'd0);
    check_eq("abort_err",   64'(err_o),   64'd0);
    check_eq("abort_k",     64'(k_o),     64'd0);
    check_eq("abort_minv",  minv_o,       64'd0);
    check_eq("abort_r2",    r2_o,         64'd0);
    check_eq("abort_no_valid", 64'(v_cnt), 64'd0);
    check_eq("abort_no_err",   64'(e_cnt), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    // start_i is still high, so the next rising edge accepts a new m=13.
    @(posedge clk_i);
    v_cnt = 0; e_cnt = 0; v_edge = -1; r_edge = -1; busy = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk_i);
      if (c == 10) start_i = 1'b0;
      if (valid_o) begin v_cnt++; if (v_edge < 0) v_edge = c; end
      if (err_o) e_cnt++;
      if (ready_o && r_edge < 0) r_edge = c;
      if (c > 10 && !ready_o) busy++;
    end
    check_eq("rerun_valid_cnt",  64'(v_cnt),  64'd1);
    check_eq("rerun_valid_edge", 64'(v_edge), 64'd9);
    check_eq("rerun_err_cnt",    64'(e_cnt),  64'd0);
    check_eq("rerun_ready_edge", 64'(r_edge), 64'd10);
    check_eq("rerun_no_second",  64'(busy),   64'd0);
    check_eq("rerun_k",    64'(k_o), 64'd4);
    check_eq("rerun_minv", minv_o,   64'd11);
    check_eq("rerun_r2",   r2_o,     64'd9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
